// File: rtl/led_ctrl_pkg.sv
// Shared constants and FSM state type for the LED frame controller.
package led_ctrl_pkg;

   localparam int unsigned GRID_BITS = 256;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NBYTES    = GRID_BITS / BYTE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_e;

   // Width of a byte index that can address nb bytes (at least one bit).
   function automatic int unsigned idx_width(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous strobe plus a rising-edge
// detector; a level held high produces a single one-cycle pulse.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Shift the raw strobe through the synchronizer, then keep one cycle of history.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q[0] <= async_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/led_controller_final.sv
// Frame sender: latches a grid image on request and presents it one byte at
// a time, advancing on each synchronized rising edge of arduinoClock.
module led_controller_final #(
   parameter int unsigned GRID_BITS   = led_ctrl_pkg::GRID_BITS,
   parameter int unsigned BYTE_W      = led_ctrl_pkg::BYTE_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 arduinoClock,
   input  logic                 ledstart,
   input  logic [GRID_BITS-1:0] values,
   output logic [BYTE_W-1:0]    ledOut,
   output logic                 arduinoStart,
   output logic                 temp
);

   import led_ctrl_pkg::state_e;
   import led_ctrl_pkg::IDLE;
   import led_ctrl_pkg::LOAD;
   import led_ctrl_pkg::SEND;
   import led_ctrl_pkg::DONE;

   localparam int unsigned NB    = GRID_BITS / BYTE_W;
   localparam int unsigned IDX_W = led_ctrl_pkg::idx_width(NB);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       index_q, index_d;
   logic [GRID_BITS-1:0]   frame_q, frame_d;
   logic [BYTE_W-1:0]      led_q, led_d;
   logic                   start_q, start_d;
   logic                   temp_q, temp_d;
   logic                   adv;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (arduinoClock),
      .edge_o  (adv)
   );

   // Next-state and registered-output decode; outputs hold unless a transition changes them.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      frame_d = frame_q;
      led_d   = led_q;
      start_d = start_q;
      temp_d  = temp_q;

      unique case (state_q)
         IDLE: begin
            led_d   = '0;
            start_d = 1'b0;
            temp_d  = 1'b0;
            if (ledstart) begin
               state_d = LOAD;
            end
         end

         LOAD: begin
            frame_d = values;
            index_d = '0;
            if (!ledstart) begin
               state_d = IDLE;
               led_d   = '0;
               start_d = 1'b0;
               temp_d  = 1'b0;
            end else begin
               // frame_q is only written on this edge, so byte 0 comes straight from values.
               state_d = SEND;
               led_d   = values[BYTE_W-1:0];
               start_d = 1'b1;
               temp_d  = (LAST_IDX == '0);
            end
         end

         SEND: begin
            if (!ledstart) begin
               state_d = IDLE;
               led_d   = '0;
               start_d = 1'b0;
               temp_d  = 1'b0;
            end else if (adv) begin
               if (index_q != LAST_IDX) begin
                  index_d = index_q + 1'b1;
                  led_d   = frame_q[int'(index_d)*BYTE_W +: BYTE_W];
                  temp_d  = (index_d == LAST_IDX);
               end else begin
                  state_d = DONE;
                  led_d   = '0;
                  start_d = 1'b0;
                  temp_d  = 1'b0;
               end
            end
         end

         DONE: begin
            led_d   = '0;
            start_d = 1'b0;
            temp_d  = 1'b0;
            if (!ledstart) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            led_d   = '0;
            start_d = 1'b0;
            temp_d  = 1'b0;
         end
      endcase
   end

   // State, frame and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         index_q <= '0;
         frame_q <= '0;
         led_q   <= '0;
         start_q <= 1'b0;
         temp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         frame_q <= frame_d;
         led_q   <= led_d;
         start_q <= start_d;
         temp_q  <= temp_d;
      end
   end

   assign ledOut       = led_q;
   assign arduinoStart = start_q;
   assign temp         = temp_q;

endmodule

// File: tb/tb_led_controller_final.sv
// Scoreboard bench: the stimulus side predicts the sequence of distinct
// {ledOut, arduinoStart, temp} values; a monitor pops one per observed change.
module tb_led_controller_final;

   localparam int unsigned NB = led_ctrl_pkg::NBYTES;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         arduinoClock = 1'b0;
   logic         ledstart = 1'b0;
   logic [255:0] values = '0;
   logic [7:0]   ledOut;
   logic         arduinoStart;
   logic         temp;

   led_controller_final #(
      .GRID_BITS   (256),
      .BYTE_W      (8),
      .SYNC_STAGES (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .arduinoClock (arduinoClock),
      .ledstart     (ledstart),
      .values       (values),
      .ledOut       (ledOut),
      .arduinoStart (arduinoStart),
      .temp         (temp)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   logic [9:0] exp_q[$];
   logic [9:0] last_pushed = '0;
   logic [9:0] last_seen   = '0;
   bit         mon_en      = 1'b0;

   // Reference model: the latched frame as bytes, and which byte is on show.
   logic [7:0] fb [NB];
   bit         sending = 1'b0;
   int         k       = 0;

   function automatic logic [9:0] obs();
      return {ledOut, arduinoStart, temp};
   endfunction

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got led=%h start=%b temp=%b, expected led=%h start=%b temp=%b",
                  name, act[9:2], act[1], act[0], expv[9:2], expv[1], expv[0]);
      end
   endtask

   task automatic push_exp(input logic [9:0] t);
      if (t !== last_pushed) begin
         exp_q.push_back(t);
         last_pushed = t;
      end
   endtask

   function automatic logic [9:0] shown(input int idx);
      return {fb[idx], 1'b1, 1'(idx == int'(NB) - 1)};
   endfunction

   // Monitor: every change of the observable outputs must match the next prediction.
   always @(negedge clock) begin
      logic [9:0] cur;
      if (mon_en) begin
         cur = obs();
         if (cur !== last_seen) begin
            if (exp_q.size() == 0) chk("unexpected_change", cur, last_pushed);
            else                   chk("output_seq", cur, exp_q.pop_front());
            last_seen = cur;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [255:0] rand_frame();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic start_frame(input logic [255:0] v);
      values = v;
      for (int i = 0; i < int'(NB); i++) fb[i] = v[8*i +: 8];
      k = 0;
      sending = 1'b1;
      push_exp(shown(0));
      ledstart = 1'b1;
      tick(3);
   endtask

   task automatic pulse(input int h, input int l);
      arduinoClock = 1'b1;
      if (sending) begin
         k++;
         if (k >= int'(NB)) begin
            sending = 1'b0;
            push_exp('0);
         end else begin
            push_exp(shown(k));
         end
      end
      tick(h);
      arduinoClock = 1'b0;
      tick(l);
   endtask

   task automatic stop_frame();
      tick(3);
      ledstart = 1'b0;
      if (sending) push_exp('0);
      sending = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [255:0] v;
      logic [255:0] ramp;

      #1 reset = 1'b0;
      tick(3);
      chk("reset_state", obs(), '0);
      mon_en = 1'b1;
      reset = 1'b1;
      tick(2);

      // Ramp frame: byte k = k, with an explicit latency check on the first pulse.
      for (int i = 0; i < 32; i++) ramp[8*i +: 8] = 8'(i);
      start_frame(ramp);
      arduinoClock = 1'b1;
      k = 1;
      push_exp(shown(1));
      tick(2);
      chk("latency_before", obs(), {8'h00, 1'b1, 1'b0});
      tick(1);
      chk("latency_after", obs(), {8'h01, 1'b1, 1'b0});
      arduinoClock = 1'b0;
      tick(1);
      for (int i = 1; i < 32; i++) pulse(2, 2);
      tick(3);
      chk("ramp_done_zero", obs(), '0);
      stop_frame();

      // No arduinoClock: byte 0 held indefinitely.
      v = rand_frame();
      start_frame(v);
      tick(50);
      chk("hold_no_clock", obs(), {v[7:0], 1'b1, 1'b0});
      stop_frame();

      // Frame input overwritten with all ones after LOAD.
      start_frame(rand_frame());
      values = '1;
      for (int i = 0; i < 32; i++) pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      stop_frame();

      // Abort after 10 pulses, then restart from byte 0.
      v = rand_frame();
      start_frame(v);
      for (int i = 0; i < 10; i++) pulse(2, 2);
      stop_frame();
      chk("abort_zero", obs(), '0);
      start_frame(v);
      tick(1);
      chk("restart_byte0", obs(), {v[7:0], 1'b1, 1'b0});
      for (int i = 0; i < 3; i++) pulse(1, 1);
      stop_frame();

      // Abort while in LOAD: nothing is ever presented.
      values = rand_frame();
      ledstart = 1'b1;
      tick(1);
      ledstart = 1'b0;
      tick(3);
      chk("load_abort", obs(), '0);

      // Reset asserted between clock edges mid-frame.
      start_frame(rand_frame());
      for (int i = 0; i < 5; i++) pulse(2, 2);
      tick(3);
      @(posedge clock);
      #2;
      reset = 1'b0;
      sending = 1'b0;
      push_exp('0);
      #1;
      chk("reset_immediate", obs(), '0);
      for (int i = 0; i < 5; i++) pulse(1, 1);
      ledstart = 1'b0;
      tick(2);
      chk("reset_quiet", obs(), '0);
      reset = 1'b1;
      tick(3);

      // ledstart held after DONE: extra pulses start nothing.
      v = rand_frame();
      start_frame(v);
      for (int i = 0; i < 32; i++) pulse(1, 2);
      tick(3);
      for (int i = 0; i < 3; i++) pulse(2, 2);
      tick(3);
      chk("done_hold", obs(), '0);
      ledstart = 1'b0;
      tick(2);
      start_frame(v);
      for (int i = 0; i < 2; i++) pulse(2, 1);
      stop_frame();

      // Randomized frames with random pulse counts and shapes.
      for (int f = 0; f < 6; f++) begin
         int n;
         n = int'($urandom_range(0, 40));
         start_frame(rand_frame());
         for (int i = 0; i < n; i++) pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
         stop_frame();
      end

      tick(5);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL queue_drain: got %0d predictions left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
